// File: rtl/miner_nonce_checker.sv
// ---------------------------------------------------------------------------
// miner_nonce_checker
//
// Nonce counter and difficulty-target check for one mining lane. It sits
// between the SHA-256 core and the miner control FSM: it hands the current
// nonce to the hash path, compares every finished digest against the loaded
// target, and holds a winning nonce until the output stage acknowledges it.
//
// Ports
//   clk          in   1        clock, rising edge
//   n_rst        in   1        asynchronous, active-low reset
//   load         in   1        pulse: new work, latches start_nonce/target
//   start_nonce  in   NONCE_W  first nonce of the new work
//   target       in   HASH_W   difficulty target
//   count_enable in   1        advance nonce by one
//   hash_done    in   1        pulse: digest valid on hash_in
//   hash_in      in   HASH_W   digest from the SHA core
//   result_ack   in   1        output stage consumed found_nonce
//   nonce        out  NONCE_W  current nonce to the hash path
//   finished     out  1        one-cycle pulse: digest check complete
//   send_data    out  1        level: winning nonce held in found_nonce
//   nonce_flag   out  1        level: nonce space exhausted, no winner
//   found_nonce  out  NONCE_W  nonce of the winning digest
// ---------------------------------------------------------------------------
module miner_nonce_checker #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic [NONCE_W-1:0] start_nonce,
    input  logic [HASH_W-1:0]  target,
    input  logic               count_enable,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  hash_in,
    input  logic               result_ack,
    output logic [NONCE_W-1:0] nonce,
    output logic               finished,
    output logic               send_data,
    output logic               nonce_flag,
    output logic [NONCE_W-1:0] found_nonce
);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        CHECK,
        FOUND,
        EXHAUSTED
    } state_t;

    localparam logic [NONCE_W-1:0] NONCE_MAX = '1;

    state_t               state_q;
    state_t               state_d;
    logic [HASH_W-1:0]    hash_q;
    logic [HASH_W-1:0]    hash_d;
    logic [HASH_W-1:0]    target_q;
    logic [HASH_W-1:0]    target_d;
    logic [NONCE_W-1:0]   cand_q;
    logic [NONCE_W-1:0]   cand_d;
    logic [NONCE_W-1:0]   nonce_d;
    logic [NONCE_W-1:0]   found_d;
    logic                 finished_d;
    logic                 send_d;
    logic                 flag_d;
    logic                 wrap;

    // Advancing past the last nonce ends the search for this work unit.
    assign wrap = count_enable && (nonce == NONCE_MAX);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-datapath decisions. load wins over everything else
    // in every state, so any coincident hash_done/count_enable/result_ack is
    // simply lost. In CHECK the counter is frozen so the nonce cannot move
    // while a digest is still being judged.
    always_comb begin
        state_d    = state_q;
        hash_d     = hash_q;
        target_d   = target_q;
        cand_d     = cand_q;
        nonce_d    = nonce;
        found_d    = found_nonce;
        finished_d = 1'b0;
        send_d     = send_data;
        flag_d     = nonce_flag;

        if (load) begin
            nonce_d  = start_nonce;
            target_d = target;
            send_d   = 1'b0;
            flag_d   = 1'b0;
            state_d  = SEARCH;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (wrap) begin
                        // A digest arriving with the wrap is dropped.
                        nonce_d = '0;
                        flag_d  = 1'b1;
                        state_d = EXHAUSTED;
                    end else begin
                        if (count_enable) begin
                            nonce_d = nonce + NONCE_W'(1);
                        end
                        if (hash_done) begin
                            // Candidate is the nonce the digest was made from,
                            // i.e. the value before any same-cycle increment.
                            hash_d  = hash_in;
                            cand_d  = nonce;
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    finished_d = 1'b1;
                    if (hash_q < target_q) begin
                        send_d  = 1'b1;
                        found_d = cand_q;
                        state_d = FOUND;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                FOUND: begin
                    if (result_ack) begin
                        send_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Datapath and output registers; every output is registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hash_q      <= '0;
            target_q    <= '0;
            cand_q      <= '0;
            nonce       <= '0;
            found_nonce <= '0;
            finished    <= 1'b0;
            send_data   <= 1'b0;
            nonce_flag  <= 1'b0;
        end else begin
            hash_q      <= hash_d;
            target_q    <= target_d;
            cand_q      <= cand_d;
            nonce       <= nonce_d;
            found_nonce <= found_d;
            finished    <= finished_d;
            send_data   <= send_d;
            nonce_flag  <= flag_d;
        end
    end

endmodule

// File: tb/tb_miner_nonce_checker.sv
// ---------------------------------------------------------------------------
// tb_miner_nonce_checker
//
// Directed scenarios plus a randomized run for miner_nonce_checker. A
// transaction-level model (flags for "searching", "digest pending",
// "winner held") predicts the outputs after every clock edge.
// ---------------------------------------------------------------------------
module tb_miner_nonce_checker;

    localparam int NW = 32;
    localparam int HW = 256;
    localparam logic [HW-1:0] HASH_ONE = 256'd1;

    logic          clk;
    logic          n_rst;
    logic          load;
    logic [NW-1:0] start_nonce;
    logic [HW-1:0] target;
    logic          count_enable;
    logic          hash_done;
    logic [HW-1:0] hash_in;
    logic          result_ack;
    logic [NW-1:0] nonce;
    logic          finished;
    logic          send_data;
    logic          nonce_flag;
    logic [NW-1:0] found_nonce;

    int n_checks;
    int n_fail;

    // Model state
    logic [NW-1:0] m_nonce;
    logic [HW-1:0] m_tgt;
    logic [HW-1:0] m_hash;
    logic [NW-1:0] m_cand;
    logic [NW-1:0] m_found;
    logic          m_fin;
    logic          m_send;
    logic          m_flag;
    bit            searching;
    bit            pending;
    bit            held;

    miner_nonce_checker #(.NONCE_W(NW), .HASH_W(HW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .load         (load),
        .start_nonce  (start_nonce),
        .target       (target),
        .count_enable (count_enable),
        .hash_done    (hash_done),
        .hash_in      (hash_in),
        .result_ack   (result_ack),
        .nonce        (nonce),
        .finished     (finished),
        .send_data    (send_data),
        .nonce_flag   (nonce_flag),
        .found_nonce  (found_nonce)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_nonce   = '0;
        m_tgt     = '0;
        m_hash    = '0;
        m_cand    = '0;
        m_found   = '0;
        m_fin     = 1'b0;
        m_send    = 1'b0;
        m_flag    = 1'b0;
        searching = 0;
        pending   = 0;
        held      = 0;
    endtask

    // One clock of lane behaviour at transaction level.
    task automatic model_update(input logic ld, input logic [NW-1:0] sn,
                                input logic [HW-1:0] tg, input logic ce,
                                input logic hd, input logic [HW-1:0] hi,
                                input logic ack);
        m_fin = 1'b0;
        if (ld) begin
            m_nonce   = sn;
            m_tgt     = tg;
            m_send    = 1'b0;
            m_flag    = 1'b0;
            searching = 1;
            pending   = 0;
            held      = 0;
        end else if (pending) begin
            pending = 0;
            m_fin   = 1'b1;
            if (m_hash < m_tgt) begin
                held      = 1;
                searching = 0;
                m_send    = 1'b1;
                m_found   = m_cand;
            end
        end else if (held) begin
            if (ack) begin
                held   = 0;
                m_send = 1'b0;
            end
        end else if (searching) begin
            if (ce && m_nonce == 32'hFFFF_FFFF) begin
                m_nonce   = '0;
                m_flag    = 1'b1;
                searching = 0;
            end else begin
                if (hd) begin
                    pending = 1;
                    m_hash  = hi;
                    m_cand  = m_nonce;
                end
                if (ce) m_nonce = m_nonce + 32'd1;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then settle.
    task automatic step(input logic ld, input logic [NW-1:0] sn,
                        input logic [HW-1:0] tg, input logic ce,
                        input logic hd, input logic [HW-1:0] hi,
                        input logic ack);
        load         = ld;
        start_nonce  = sn;
        target       = tg;
        count_enable = ce;
        hash_done    = hd;
        hash_in      = hi;
        result_ack   = ack;
        @(posedge clk);
        model_update(ld, sn, tg, ce, hd, hi, ack);
        #1;
        load         = 1'b0;
        count_enable = 1'b0;
        hash_done    = 1'b0;
        result_ack   = 1'b0;
    endtask

    task automatic idle_cycle();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++; if (nonce !== 32'h0)       begin n_fail++; $display("[TB] FAIL reset_nonce got %h exp 0", nonce); end
        n_checks++; if (finished !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_finished got %b exp 0", finished); end
        n_checks++; if (send_data !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_send got %b exp 0", send_data); end
        n_checks++; if (nonce_flag !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_flag got %b exp 0", nonce_flag); end
        n_checks++; if (found_nonce !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_found got %h exp 0", found_nonce); end
        n_rst = 1'b1;
        // Idle ignores count_enable.
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (nonce !== 32'h0) begin n_fail++; $display("[TB] FAIL idle_count got %h exp 0", nonce); end
    endtask

    task automatic test_win();
        step(1'b1, 32'h10, HASH_ONE << 240, 1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (nonce !== 32'h10) begin n_fail++; $display("[TB] FAIL win_load_nonce got %h exp 10", nonce); end
        step(1'b0, '0, '0, 1'b0, 1'b1, HASH_ONE << 239, 1'b0);
        n_checks++; if (finished !== 1'b0) begin n_fail++; $display("[TB] FAIL win_early_fin got %b exp 0", finished); end
        idle_cycle();
        n_checks++; if (finished !== 1'b1)       begin n_fail++; $display("[TB] FAIL win_fin got %b exp 1", finished); end
        n_checks++; if (send_data !== 1'b1)      begin n_fail++; $display("[TB] FAIL win_send got %b exp 1", send_data); end
        n_checks++; if (found_nonce !== 32'h10)  begin n_fail++; $display("[TB] FAIL win_found got %h exp 10", found_nonce); end
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        n_checks++; if (send_data !== 1'b0) begin n_fail++; $display("[TB] FAIL win_ack_send got %b exp 0", send_data); end
        n_checks++; if (finished !== 1'b0)  begin n_fail++; $display("[TB] FAIL win_fin_width got %b exp 0", finished); end
    endtask

    task automatic test_miss();
        step(1'b1, 32'h10, HASH_ONE << 240, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, HASH_ONE << 240, 1'b0);
        idle_cycle();
        n_checks++; if (finished !== 1'b1)  begin n_fail++; $display("[TB] FAIL miss_fin got %b exp 1", finished); end
        n_checks++; if (send_data !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_send got %b exp 0", send_data); end
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (nonce !== 32'h11) begin n_fail++; $display("[TB] FAIL miss_count got %h exp 11", nonce); end
    endtask

    task automatic test_wrap();
        step(1'b1, 32'hFFFF_FFFE, HASH_ONE << 240, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (nonce !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL wrap_pre got %h exp ffffffff", nonce); end
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (nonce !== 32'h0)      begin n_fail++; $display("[TB] FAIL wrap_nonce got %h exp 0", nonce); end
        n_checks++; if (nonce_flag !== 1'b1)  begin n_fail++; $display("[TB] FAIL wrap_flag got %b exp 1", nonce_flag); end
        step(1'b0, '0, '0, 1'b1, 1'b1, HASH_ONE, 1'b0);
        idle_cycle();
        n_checks++; if (finished !== 1'b0)   begin n_fail++; $display("[TB] FAIL wrap_hash_ignored got %b exp 0", finished); end
        n_checks++; if (nonce !== 32'h0)     begin n_fail++; $display("[TB] FAIL wrap_frozen got %h exp 0", nonce); end
        n_checks++; if (nonce_flag !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_flag_held got %b exp 1", nonce_flag); end
    endtask

    task automatic test_priority();
        step(1'b1, 32'h30, HASH_ONE << 240, 1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (nonce_flag !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_flag_clear got %b exp 0", nonce_flag); end
        step(1'b1, 32'h40, HASH_ONE << 240, 1'b1, 1'b1, HASH_ONE, 1'b0);
        n_checks++; if (nonce !== 32'h40) begin n_fail++; $display("[TB] FAIL prio_nonce got %h exp 40", nonce); end
        idle_cycle();
        idle_cycle();
        n_checks++; if (finished !== 1'b0)  begin n_fail++; $display("[TB] FAIL prio_fin got %b exp 0", finished); end
        n_checks++; if (send_data !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_send got %b exp 0", send_data); end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 32'h20, HASH_ONE << 240, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, HASH_ONE << 239, 1'b0);
        n_checks++; if (nonce !== 32'h21) begin n_fail++; $display("[TB] FAIL sim_nonce got %h exp 21", nonce); end
        // Counter frozen while the digest is being checked.
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (finished !== 1'b1)      begin n_fail++; $display("[TB] FAIL sim_fin got %b exp 1", finished); end
        n_checks++; if (send_data !== 1'b1)     begin n_fail++; $display("[TB] FAIL sim_send got %b exp 1", send_data); end
        n_checks++; if (found_nonce !== 32'h20) begin n_fail++; $display("[TB] FAIL sim_found got %h exp 20", found_nonce); end
        n_checks++; if (nonce !== 32'h21)       begin n_fail++; $display("[TB] FAIL sim_frozen got %h exp 21", nonce); end
        // Ack releases the winner.
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid_check();
        step(1'b1, 32'h10, HASH_ONE << 240, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, HASH_ONE << 239, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (nonce !== 32'h0)       begin n_fail++; $display("[TB] FAIL rst_mid_nonce got %h exp 0", nonce); end
        n_checks++; if (found_nonce !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_found got %h exp 0", found_nonce); end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle_cycle();
        n_checks++; if (finished !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_mid_fin got %b exp 0", finished); end
        n_checks++; if (send_data !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_send got %b exp 0", send_data); end
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_checks++; if (nonce !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_idle got %h exp 0", nonce); end
    endtask

    task automatic test_random();
        logic          ld;
        logic          ce;
        logic          hd;
        logic          ack;
        logic [NW-1:0] sn;
        logic [HW-1:0] tg;
        logic [HW-1:0] hi;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ld  = (cyc == 0) || ($urandom_range(0, 99) < 4);
            ce  = ($urandom_range(0, 99) < 45);
            hd  = ($urandom_range(0, 99) < 25);
            ack = ($urandom_range(0, 99) < 30);
            sn  = ($urandom_range(0, 1) == 0) ? 32'(32'hFFFF_FFF0 + $urandom_range(0, 15)) : 32'($urandom);
            for (int w = 0; w < 8; w++) begin
                tg[w*32 +: 32] = 32'($urandom);
                hi[w*32 +: 32] = 32'($urandom);
            end
            // Make sure the model's current target can be hit exactly.
            case ($urandom_range(0, 2))
                0: hi = m_tgt;
                1: hi = m_tgt - HASH_ONE;
                default: ;
            endcase
            step(ld, sn, tg, ce, hd, hi, ack);
            n_checks++; if (nonce !== m_nonce)       begin n_fail++; $display("[TB] FAIL rnd_nonce cyc %0d got %h exp %h", cyc, nonce, m_nonce); end
            n_checks++; if (finished !== m_fin)      begin n_fail++; $display("[TB] FAIL rnd_fin cyc %0d got %b exp %b", cyc, finished, m_fin); end
            n_checks++; if (send_data !== m_send)    begin n_fail++; $display("[TB] FAIL rnd_send cyc %0d got %b exp %b", cyc, send_data, m_send); end
            n_checks++; if (nonce_flag !== m_flag)   begin n_fail++; $display("[TB] FAIL rnd_flag cyc %0d got %b exp %b", cyc, nonce_flag, m_flag); end
            n_checks++; if (found_nonce !== m_found) begin n_fail++; $display("[TB] FAIL rnd_found cyc %0d got %h exp %h", cyc, found_nonce, m_found); end
        end
    endtask

    // Scenario sequence.
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_rst        = 1'b0;
        load         = 1'b0;
        start_nonce  = '0;
        target       = '0;
        count_enable = 1'b0;
        hash_done    = 1'b0;
        hash_in      = '0;
        result_ack   = 1'b0;
        model_reset();
        test_reset();
        test_win();
        test_miss();
        test_wrap();
        test_priority();
        test_simultaneous();
        test_reset_mid_check();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
